// File: rtl/dp_seq.sv
// Self-sequencing datapath: register file, A/B/C pipeline registers, B shifter,
// 4-op ALU with {V,N,Z} status and 4-source writeback, run by a command FSM.
module dp_seq #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG),
  parameter int PCW  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    alu_op,
  input  logic [1:0]    shift,
  input  logic [AW-1:0] rn,
  input  logic [AW-1:0] rm,
  input  logic [AW-1:0] rd,
  input  logic          zero_a,
  input  logic          use_imm,
  input  logic [W-1:0]  imm,
  input  logic [1:0]    vsel,
  input  logic          write_en,
  input  logic          set_flags,
  input  logic [W-1:0]  mdata,
  input  logic [PCW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [2:0]    flags,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WB
  } state_t;

  state_t r_state, w_next;

  logic [1:0]     r_alu_op, r_shift, r_vsel;
  logic [AW-1:0]  r_rn, r_rm, r_rd;
  logic           r_zero_a, r_use_imm, r_write_en, r_set_flags;
  logic [W-1:0]   r_imm, r_mdata;
  logic [PCW-1:0] r_pc;

  logic [W-1:0]   r_regs [NREG];
  logic [W-1:0]   r_a, r_b, r_c;
  logic [2:0]     r_flags;

  logic [W-1:0]   w_ain, w_bsh, w_bin, w_alu, w_wb_data;
  logic           w_v, w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_WB);
    case (r_state)
      S_IDLE:   if (start) w_next = (vsel == 2'b00) ? S_LOAD_A : S_WB;
      S_LOAD_A: w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_bsh = r_b;
    case (r_shift)
      2'b01:   w_bsh = {r_b[W-2:0], 1'b0};
      2'b10:   w_bsh = {1'b0, r_b[W-1:1]};
      2'b11:   w_bsh = {r_b[W-1], r_b[W-1:1]};
      default: w_bsh = r_b;
    endcase
  end

  assign w_ain = r_zero_a ? '0 : r_a;
  assign w_bin = r_use_imm ? r_imm : w_bsh;

  // Overflow is judged on the operands actually presented to the adder.
  always_comb begin
    w_alu = '0;
    w_v   = 1'b0;
    case (r_alu_op)
      2'b00: begin
        w_alu = w_ain + w_bin;
        w_v   = (w_ain[W-1] == w_bin[W-1]) && (w_alu[W-1] != w_ain[W-1]);
      end
      2'b01: begin
        w_alu = w_ain - w_bin;
        w_v   = (w_ain[W-1] != w_bin[W-1]) && (w_alu[W-1] != w_ain[W-1]);
      end
      2'b10:   w_alu = w_ain & w_bin;
      default: w_alu = ~w_bin;
    endcase
  end

  always_comb begin
    w_wb_data = r_c;
    case (r_vsel)
      2'b01:   w_wb_data = W'(r_pc);
      2'b10:   w_wb_data = r_imm;
      2'b11:   w_wb_data = r_mdata;
      default: w_wb_data = r_c;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_op    <= '0;
      r_shift     <= '0;
      r_vsel      <= '0;
      r_rn        <= '0;
      r_rm        <= '0;
      r_rd        <= '0;
      r_zero_a    <= 1'b0;
      r_use_imm   <= 1'b0;
      r_write_en  <= 1'b0;
      r_set_flags <= 1'b0;
      r_imm       <= '0;
      r_mdata     <= '0;
      r_pc        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_flags     <= '0;
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_accept) begin
        r_alu_op    <= alu_op;
        r_shift     <= shift;
        r_vsel      <= vsel;
        r_rn        <= rn;
        r_rm        <= rm;
        r_rd        <= rd;
        r_zero_a    <= zero_a;
        r_use_imm   <= use_imm;
        r_write_en  <= write_en;
        r_set_flags <= set_flags;
        r_imm       <= imm;
        r_mdata     <= mdata;
        r_pc        <= pc;
      end
      case (r_state)
        S_LOAD_A: r_a <= r_regs[r_rn];
        S_LOAD_B: r_b <= r_regs[r_rm];
        S_EXEC: begin
          r_c <= w_alu;
          if (r_set_flags) r_flags <= {w_v, w_alu[W-1], (w_alu == '0)};
        end
        S_WB:     if (r_write_en) r_regs[r_rd] <= w_wb_data;
        default: ;
      endcase
    end
  end

  assign result   = r_c;
  assign flags    = r_flags;
  assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_dp_seq.sv
// Scoreboard bench for dp_seq: stimulus pushes hand-computed expectations,
// per-instance monitors pop and compare on each done pulse (W=16 and W=8 builds).
module tb_dp_seq;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [2:0]  rd;
    logic        za;
    logic        ui;
    logic [15:0] imm;
    logic [1:0]  vs;
    logic        we;
    logic        sf;
    logic [15:0] md;
    logic [7:0]  pc;
  } cmd_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  fl;
    int          lat;
    logic [15:0] rv;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // ---------------- W=16, NREG=8 instance ----------------
  cmd_t        c16 = '0;
  logic        rst16_n = 1'b0, start16 = 1'b0;
  logic [2:0]  dbg16 = '0;
  logic        busy16, done16;
  logic [15:0] res16, dd16;
  logic [2:0]  fl16;
  exp_t        q16[$];
  logic        act16 = 1'b0;

  dp_seq #(.W(16), .NREG(8), .PCW(8)) dut16 (
    .clk(clk), .reset_n(rst16_n), .start(start16),
    .alu_op(c16.op), .shift(c16.sh), .rn(c16.rn), .rm(c16.rm), .rd(c16.rd),
    .zero_a(c16.za), .use_imm(c16.ui), .imm(c16.imm), .vsel(c16.vs),
    .write_en(c16.we), .set_flags(c16.sf), .mdata(c16.md), .pc(c16.pc),
    .busy(busy16), .done(done16), .result(res16), .flags(fl16),
    .dbg_addr(dbg16), .dbg_data(dd16)
  );

  // ---------------- W=8, NREG=4 instance ----------------
  cmd_t        c8 = '0;
  logic        rst8_n = 1'b0, start8 = 1'b0;
  logic [1:0]  dbg8 = '0;
  logic        busy8, done8;
  logic [7:0]  res8, dd8;
  logic [2:0]  fl8;
  exp_t        q8[$];
  logic        act8 = 1'b0;

  dp_seq #(.W(8), .NREG(4), .PCW(8)) dut8 (
    .clk(clk), .reset_n(rst8_n), .start(start8),
    .alu_op(c8.op), .shift(c8.sh), .rn(c8.rn[1:0]), .rm(c8.rm[1:0]), .rd(c8.rd[1:0]),
    .zero_a(c8.za), .use_imm(c8.ui), .imm(c8.imm[7:0]), .vsel(c8.vs),
    .write_en(c8.we), .set_flags(c8.sf), .mdata(c8.md[7:0]), .pc(c8.pc),
    .busy(busy8), .done(done8), .result(res8), .flags(fl8),
    .dbg_addr(dbg8), .dbg_data(dd8)
  );

  // ---------------- monitors ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done16) begin
      if (q16.size() == 0) begin
        chk("d16_unexpected_done", 32'(done16), 32'd0);
      end else begin
        act16 = 1'b1;
        e = q16.pop_front();
        chk("d16_latency", 32'(cyc - e.t), 32'(e.lat));
        chk("d16_busy_in_wb", 32'(busy16), 32'd1);
        chk("d16_result", 32'(res16), 32'(e.res));
        chk("d16_flags", 32'(fl16), 32'(e.fl));
        @(negedge clk);
        chk("d16_reg", 32'(dd16), 32'(e.rv));
        chk("d16_busy_after", 32'(busy16), 32'd0);
        chk("d16_done_after", 32'(done16), 32'd0);
        act16 = 1'b0;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done8) begin
      if (q8.size() == 0) begin
        chk("d8_unexpected_done", 32'(done8), 32'd0);
      end else begin
        act8 = 1'b1;
        e = q8.pop_front();
        chk("d8_latency", 32'(cyc - e.t), 32'(e.lat));
        chk("d8_result", 32'(res8), 32'(e.res));
        chk("d8_flags", 32'(fl8), 32'(e.fl));
        @(negedge clk);
        chk("d8_reg", 32'(dd8), 32'(e.rv));
        chk("d8_busy_after", 32'(busy8), 32'd0);
        act8 = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic cmd_t mk(logic [1:0] op, logic [1:0] sh, logic [2:0] rn,
                              logic [2:0] rm, logic [2:0] rd, logic za, logic ui,
                              logic [15:0] imm, logic [1:0] vs, logic we, logic sf,
                              logic [15:0] md, logic [7:0] pc);
    cmd_t c;
    c = '{op: op, sh: sh, rn: rn, rm: rm, rd: rd, za: za, ui: ui, imm: imm,
          vs: vs, we: we, sf: sf, md: md, pc: pc};
    return c;
  endfunction

  function automatic exp_t ex(logic [15:0] res, logic [2:0] fl, int lat, logic [15:0] rv);
    exp_t e;
    e = '{res: res, fl: fl, lat: lat, rv: rv, t: 0};
    return e;
  endfunction

  task automatic send16(input cmd_t c, input exp_t e);
    @(negedge clk);
    c16 = c;
    dbg16 = c.rd;
    start16 = 1'b1;
    e.t = cyc + 1;
    q16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
    c16 = '1;
  endtask

  task automatic wait16();
    int n = 0;
    while ((q16.size() != 0 || act16) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0 || act16) begin
      errors++;
      $display("FAIL d16_timeout: pending %0d expected 0", q16.size());
      q16.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run16(input cmd_t c, input exp_t e);
    send16(c, e);
    wait16();
  endtask

  task automatic run8(input cmd_t c, input exp_t e);
    int n = 0;
    @(negedge clk);
    c8 = c;
    dbg8 = c.rd[1:0];
    start8 = 1'b1;
    e.t = cyc + 1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    c8 = '1;
    while ((q8.size() != 0 || act8) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || act8) begin
      errors++;
      $display("FAIL d8_timeout: pending %0d expected 0", q8.size());
      q8.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst16_n = 1'b1;
    rst8_n  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg16 = 3'(i);
      #1 chk("rst16_reg", 32'(dd16), 32'd0);
    end
    chk("rst16_flags", 32'(fl16), 32'd0);
    chk("rst16_busy", 32'(busy16), 32'd0);
    chk("rst16_done", 32'(done16), 32'd0);
    chk("rst16_result", 32'(res16), 32'd0);

    //       op    sh    rn rm rd za ui imm       vs    we sf md       pc
    run16(mk(2'b00,2'b00,0, 0, 0, 0, 0, 16'h0007, 2'b10,1, 0, 16'h0,   8'h0),  ex(16'h0000,3'b000,0,16'h0007));
    run16(mk(2'b00,2'b00,0, 0, 1, 0, 0, 16'h0002, 2'b10,1, 0, 16'h0,   8'h0),  ex(16'h0000,3'b000,0,16'h0002));
    run16(mk(2'b00,2'b01,0, 1, 2, 0, 0, 16'h0,    2'b00,1, 1, 16'h0,   8'h0),  ex(16'h000B,3'b000,3,16'h000B));
    run16(mk(2'b00,2'b00,0, 0, 3, 0, 0, 16'h7FFF, 2'b10,1, 0, 16'h0,   8'h0),  ex(16'h000B,3'b000,0,16'h7FFF));
    run16(mk(2'b00,2'b00,0, 0, 4, 0, 0, 16'hFFFF, 2'b10,1, 0, 16'h0,   8'h0),  ex(16'h000B,3'b000,0,16'hFFFF));
    run16(mk(2'b01,2'b00,3, 4, 5, 0, 0, 16'h0,    2'b00,0, 1, 16'h0,   8'h0),  ex(16'h8000,3'b110,3,16'h0000));
    run16(mk(2'b00,2'b00,0, 0, 6, 0, 0, 16'h0,    2'b11,1, 1, 16'h1234,8'h0),  ex(16'h8000,3'b110,0,16'h1234));
    run16(mk(2'b00,2'b00,0, 0, 7, 0, 0, 16'h0,    2'b01,1, 1, 16'h0,   8'hA5), ex(16'h8000,3'b110,0,16'h00A5));
    run16(mk(2'b10,2'b10,3, 4, 2, 0, 0, 16'h0,    2'b00,1, 0, 16'h0,   8'h0),  ex(16'h7FFF,3'b110,3,16'h7FFF));
    run16(mk(2'b01,2'b00,0, 0, 5, 0, 0, 16'h0,    2'b00,1, 1, 16'h0,   8'h0),  ex(16'h0000,3'b001,3,16'h0000));
    run16(mk(2'b01,2'b00,0, 0, 5, 1, 1, 16'h0003, 2'b00,1, 1, 16'h0,   8'h0),  ex(16'hFFFD,3'b010,3,16'hFFFD));
    run16(mk(2'b00,2'b00,1, 1, 1, 0, 0, 16'h0,    2'b00,1, 0, 16'h0,   8'h0),  ex(16'h0004,3'b010,3,16'h0004));

    // A start during LOAD_B must neither run nor queue.
    send16(mk(2'b00,2'b00,0, 1, 6, 0, 0, 16'h0,   2'b00,1, 0, 16'h0,   8'h0),  ex(16'h000B,3'b010,3,16'h000B));
    @(negedge clk);
    c16 = mk(2'b00,2'b00,0, 0, 0, 0, 0, 16'hDEAD, 2'b10,1, 1, 16'h0, 8'h0);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait16();
    repeat (6) @(negedge clk);
    dbg16 = 3'd0;
    #1 chk("d16_ignored_start_r0", 32'(dd16), 32'h0007);

    // Reset in EXEC aborts the command.
    send16(mk(2'b00,2'b00,0, 1, 5, 0, 0, 16'h0,   2'b00,1, 1, 16'h0,   8'h0),  ex(16'h0,3'b000,3,16'h0));
    q16.delete();
    @(negedge clk);
    @(negedge clk);
    chk("d16_busy_in_exec", 32'(busy16), 32'd1);
    #1 rst16_n = 1'b0;
    #1 chk("d16_abort_busy", 32'(busy16), 32'd0);
    chk("d16_abort_done", 32'(done16), 32'd0);
    @(negedge clk);
    rst16_n = 1'b1;
    repeat (6) @(negedge clk);
    dbg16 = 3'd5;
    #1 chk("d16_abort_rd", 32'(dd16), 32'd0);
    chk("d16_abort_flags", 32'(fl16), 32'd0);
    chk("d16_abort_result", 32'(res16), 32'd0);
    run16(mk(2'b00,2'b00,0, 0, 5, 0, 0, 16'h0055, 2'b10,1, 0, 16'h0,   8'h0),  ex(16'h0000,3'b000,0,16'h0055));

    // Narrow build.
    for (int i = 0; i < 4; i++) begin
      dbg8 = 2'(i);
      #1 chk("rst8_reg", 32'(dd8), 32'd0);
    end
    chk("rst8_flags", 32'(fl8), 32'd0);
    run8(mk(2'b00,2'b00,0, 0, 1, 0, 0, 16'h000F, 2'b10,1, 0, 16'h0,   8'h0),  ex(16'h00,3'b000,0,16'h0F));
    run8(mk(2'b11,2'b00,0, 1, 3, 0, 0, 16'h0,    2'b00,1, 1, 16'h0,   8'h0),  ex(16'hF0,3'b010,3,16'hF0));
    run8(mk(2'b00,2'b00,0, 0, 0, 0, 0, 16'h0080, 2'b10,1, 0, 16'h0,   8'h0),  ex(16'hF0,3'b010,0,16'h80));
    run8(mk(2'b00,2'b11,0, 0, 2, 1, 0, 16'h0,    2'b00,1, 1, 16'h0,   8'h0),  ex(16'hC0,3'b010,3,16'hC0));
    run8(mk(2'b00,2'b10,0, 0, 2, 1, 0, 16'h0,    2'b00,1, 1, 16'h0,   8'h0),  ex(16'h40,3'b000,3,16'h40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
